// File: rtl/fp_posit_bitserial_mac.sv
// FP16 activation x bit-serial es=0 posit weight, aligned to exp_min and added to an external addend.
// Result registered 1 cycle after the last weight bit; no backpressure, valid=0 mid-word drops the word.
module fp_posit_bitserial_mac #(
   parameter int ACT_WIDTH = 16,
   parameter int ACC_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic [3:0]           precision,
   input  logic                 set,
   input  logic [ACT_WIDTH-1:0] act,
   input  logic                 w,
   input  logic [4:0]           exp_min,
   input  logic [ACC_WIDTH-1:0] fixed_point_acc,
   output logic [4:0]           exp_out,
   output logic [ACC_WIDTH-1:0] fixed_point_out,
   output logic                 done
);

   logic [3:0]           r_cnt;
   logic [3:0]           r_prec;
   logic [3:0]           r_wprec;
   logic [6:0]           r_word;
   logic [ACT_WIDTH-1:0] r_act;
   logic [4:0]           r_exp;
   logic [4:0]           r_wexp;
   logic [ACC_WIDTH-1:0] r_out;
   logic                 r_done;

   logic                 w_last;
   logic [3:0]           w_prec_cl;
   logic [3:0]           w_lsb;
   logic [7:0]           w_word;
   logic [7:0]           w_al;
   logic [7:0]           w_mag;
   logic [7:0]           w_mag_r;
   logic [7:0]           w_frac;
   logic [7:0]           w_sig;
   logic                 w_sw;
   logic                 w_zero;
   logic                 w_r0;
   logic                 w_run;
   logic [3:0]           w_m;
   logic [3:0]           w_fn;
   logic [4:0]           w_k;
   logic [4:0]           w_ea;
   logic [10:0]          w_mant;
   logic [16:0]          w_p;
   logic [7:0]           w_sh;
   logic [7:0]           w_amt;
   logic                 w_shneg;
   logic [ACC_WIDTH-1:0] w_pext;
   logic [ACC_WIDTH-1:0] w_mag_sh;
   logic [ACC_WIDTH-1:0] w_prod;

   // First bit of a word is never the last one since N >= 3.
   assign w_last    = valid && (r_cnt != 4'd0) && (r_cnt == r_wprec - 4'd1);
   assign w_prec_cl = (precision < 4'd3) ? 4'd3 : ((precision > 4'd8) ? 4'd8 : precision);

   // Posit decode: left-align the N-bit word into 8 bits so the regime always starts at bit 6.
   always_comb begin
      w_lsb  = 4'd8 - r_wprec;
      w_word = {r_word, w};
      w_al   = w_word << w_lsb;
      w_sw   = w_al[7];
      w_zero = (w_al[6:0] == 7'd0);
      w_mag  = w_sw ? (8'd0 - w_al) : w_al;
      w_r0   = w_mag[6];
      w_run  = 1'b1;
      w_m    = 4'd0;
      for (int i = 6; i >= 0; i--) begin
         if (w_run && (i >= int'(w_lsb))) begin
            if (w_mag[3'(i)] == w_r0) w_m = w_m + 4'd1;
            else                      w_run = 1'b0;
         end
      end
      w_fn    = ((w_m + 4'd2) < r_wprec) ? (r_wprec - w_m - 4'd2) : 4'd0;
      w_mag_r = w_mag >> w_lsb;
      w_frac  = w_mag_r & ((8'd1 << w_fn) - 8'd1);
      w_sig   = (8'd1 << w_fn) | w_frac;
      w_k     = w_r0 ? ({1'b0, w_m} - 5'd1) : (5'd0 - {1'b0, w_m});
   end

   // Product and alignment; shift amount is an 8-bit two's-complement value in -42..37.
   always_comb begin
      w_ea    = r_act[14:10];
      w_mant  = {1'b1, r_act[9:0]};
      w_p     = 17'(w_mant) * 17'(w_sig);
      w_sh    = {3'b000, w_ea} - {3'b000, r_wexp} + {{3{w_k[4]}}, w_k} - {4'b0000, w_fn};
      w_shneg = w_sh[7];
      w_amt   = w_shneg ? (8'd0 - w_sh) : w_sh;
      w_pext  = ACC_WIDTH'(w_p);
      if (w_amt >= 8'(ACC_WIDTH)) w_mag_sh = '0;
      else if (w_shneg)           w_mag_sh = w_pext >> w_amt;
      else                        w_mag_sh = w_pext << w_amt;
      if (w_zero || (w_ea == 5'd0)) w_mag_sh = '0;
      w_prod = (r_act[ACT_WIDTH-1] ^ w_sw) ? ('0 - w_mag_sh) : w_mag_sh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= 4'd0;
         r_prec  <= 4'd4;
         r_wprec <= 4'd4;
         r_word  <= 7'd0;
         r_act   <= '0;
         r_exp   <= 5'd0;
         r_wexp  <= 5'd0;
         r_out   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (set) begin
            r_exp  <= exp_min;
            r_prec <= w_prec_cl;
         end
         if (!valid) begin
            r_cnt <= 4'd0;
         end else if (r_cnt == 4'd0) begin
            // Snapshot configuration so a set during the word cannot disturb it.
            r_cnt   <= 4'd1;
            r_word  <= {6'd0, w};
            r_act   <= act;
            r_wprec <= r_prec;
            r_wexp  <= r_exp;
         end else if (w_last) begin
            r_cnt  <= 4'd0;
            r_out  <= fixed_point_acc + w_prod;
            r_done <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_word <= {r_word[5:0], w};
         end
      end
   end

   assign exp_out         = r_exp;
   assign fixed_point_out = r_out;
   assign done            = r_done;

endmodule

// File: tb/tb_fp_posit_bitserial_mac.sv
// Directed and randomized bench for fp_posit_bitserial_mac against an arithmetic reference model.
module tb_fp_posit_bitserial_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  precision;
   logic        set;
   logic [15:0] act;
   logic        w;
   logic [4:0]  exp_min;
   logic [31:0] fixed_point_acc;
   logic [4:0]  exp_out;
   logic [31:0] fixed_point_out;
   logic        done;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int last_cyc = 0;
   logic [31:0] res_q[$];
   int          res_cyc_q[$];
   logic [31:0] exp_q[$];

   fp_posit_bitserial_mac dut (
      .clk             (clk),
      .rst             (rst),
      .valid           (valid),
      .precision       (precision),
      .set             (set),
      .act             (act),
      .w               (w),
      .exp_min         (exp_min),
      .fixed_point_acc (fixed_point_acc),
      .exp_out         (exp_out),
      .fixed_point_out (fixed_point_out),
      .done            (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         res_q.push_back(fixed_point_out);
         res_cyc_q.push_back(cyc);
         done_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: value-level posit/FP16 decode, product scaled by 2^(ea-emin+k-F).
   function automatic logic [31:0] model(input int word_i, input int n, input logic [15:0] a,
                                         input int emin, input logic [31:0] acc);
      int word, sw, first, m, pos, k, fb, f, ea, sh;
      longint mag;
      logic [31:0] prod;
      word = word_i & ((1 << n) - 1);
      if (word == 0 || word == (1 << (n - 1))) return acc;
      ea = int'(a[14:10]);
      if (ea == 0) return acc;
      sw = (word >> (n - 1)) & 1;
      if (sw == 1) word = ((1 << n) - word) & ((1 << n) - 1);
      first = (word >> (n - 2)) & 1;
      m = 0;
      pos = n - 2;
      while (pos >= 0 && ((word >> pos) & 1) == first) begin
         m++;
         pos--;
      end
      k  = (first == 1) ? m - 1 : -m;
      fb = (pos > 0) ? pos : 0;
      f  = word & ((1 << fb) - 1);
      sh = ea - emin + k - fb;
      mag = longint'(1024 + int'(a[9:0])) * longint'((1 << fb) + f);
      if (sh >= 0) mag = (sh >= 32) ? 64'd0 : ((mag << sh) & 64'hFFFF_FFFF);
      else         mag = (-sh >= 32) ? 64'd0 : (mag >> (-sh));
      prod = mag[31:0];
      if ((sw ^ int'(a[15])) == 1) prod = 32'd0 - prod;
      return acc + prod;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic get_result(input string tag, input logic [31:0] expv);
      int t;
      t = 0;
      while (res_q.size() == 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (res_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: no done within 40 cycles, expected result %h", tag, expv);
      end else begin
         last_cyc = res_cyc_q.pop_front();
         check32(tag, res_q.pop_front(), expv);
      end
   endtask

   task automatic send_bits(input int word, input int n, input logic [15:0] a, input logic [31:0] acc);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         valid           = 1'b1;
         w               = 1'((word >> i) & 1);
         act             = a;
         fixed_point_acc = acc;
      end
   endtask

   task automatic idle(input int c);
      repeat (c) begin
         @(negedge clk);
         valid = 1'b0;
         w     = 1'b0;
      end
   endtask

   task automatic set_cfg(input int e, input int p);
      @(negedge clk);
      valid     = 1'b0;
      set       = 1'b1;
      exp_min   = 5'(e);
      precision = 4'(p);
      @(negedge clk);
      set = 1'b0;
   endtask

   initial begin
      int d, c1, word, e;
      logic [15:0] a;
      logic [31:0] acc;
      rst = 1'b0; valid = 1'b0; set = 1'b0; w = 1'b0;
      precision = 4'd4; act = 16'h0; exp_min = 5'd0; fixed_point_acc = 32'd0;
      #1;
      check32("reset_exp_out", 32'(exp_out), 32'd0);
      check32("reset_out", fixed_point_out, 32'd0);
      check32("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Default precision 4 and exp 0 after reset, no set yet.
      send_bits(4'b0101, 4, 16'h4569, 32'd2);
      idle(1);
      get_result("reset_cfg_word", 32'h103B0002);

      set_cfg(16, 4);
      check32("set_exp_out", 32'(exp_out), 32'd16);

      d = done_cnt;
      send_bits(4'b0101, 4, 16'h4569, 32'd2);
      idle(2);
      get_result("pos_1p5", 32'h0000103D);
      idle(3);
      check32("single_done", 32'(done_cnt - d), 32'd1);
      check32("exp_out_hold", 32'(exp_out), 32'd16);
      check32("out_hold", fixed_point_out, 32'h0000103D);

      // 1100 decodes to -1.0, 1110 to -0.5; the second word runs back-to-back.
      send_bits(4'b1100, 4, 16'h4AAA, 32'd2);
      send_bits(4'b1011, 4, 16'hBE80, 32'd2);
      idle(2);
      get_result("neg_1p0", 32'hFFFFE55A);
      c1 = last_cyc;
      get_result("b2b_neg_1p5", 32'h000004E2);
      check32("b2b_gap", 32'(last_cyc - c1), 32'd4);
      send_bits(4'b1110, 4, 16'h4AAA, 32'd2);
      idle(2);
      get_result("neg_0p5", 32'hFFFFF2AE);

      send_bits(4'b0000, 4, 16'h4569, 32'd2);
      idle(2);
      get_result("zero_weight", 32'h00000002);
      send_bits(4'b0101, 4, 16'h0000, 32'd2);
      idle(2);
      get_result("zero_act", 32'h00000002);
      send_bits(4'b1000, 4, 16'h4569, 32'd2);
      idle(2);
      get_result("nar_weight", 32'h00000002);

      d = done_cnt;
      send_bits(2'b01, 2, 16'h4569, 32'd2);
      idle(1);
      send_bits(4'b0101, 4, 16'h4569, 32'd2);
      idle(3);
      get_result("drop_then_word", 32'h0000103D);
      idle(2);
      check32("drop_single_done", 32'(done_cnt - d), 32'd1);

      d = done_cnt;
      send_bits(2'b01, 2, 16'h4569, 32'd2);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check32("midrst_out", fixed_point_out, 32'd0);
      check32("midrst_exp_out", 32'(exp_out), 32'd0);
      idle(2);
      rst = 1'b1;
      idle(4);
      check32("midrst_no_done", 32'(done_cnt - d), 32'd0);

      set_cfg(15, 3);
      send_bits(3'b011, 3, 16'h3C00, 32'd2);
      idle(2);
      get_result("p3_plus2", 32'h00000802);

      for (int p = 3; p <= 8; p++) begin
         e = int'($urandom_range(0, 31));
         set_cfg(e, p);
         for (int j = 0; j < 25; j++) begin
            word = int'($urandom_range(0, (1 << p) - 1));
            a    = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a[14:10] = 5'd0;
            acc  = $urandom;
            exp_q.push_back(model(word, p, a, e, acc));
            send_bits(word, p, a, acc);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
         idle(3);
         while (exp_q.size() != 0) get_result($sformatf("rand_p%0d", p), exp_q.pop_front());
      end
      idle(4);
      check32("no_extra_done", 32'(res_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
